pull_rr_arbiter: RTL
====================

Name: pull_rr_arbiter

Overview:
Round-robin arbiter sharing one upstream pull-handshake source (an async_operator output or a producer) among num_req downstream requesters. It uses the same pull protocol as the dataflow fabric:
- The consumer side holds req.
- The source answers with a one-cycle ack plus data.
It sits between one operator's output and several consumers when the datum must go to exactly one of them, not be broadcast.

Parameters:
data_width, 32, datum width in bits
num_req, 4, number of downstream requesters (2..16)
idx_width, 2, width of grant index; must be >= clog2(num_req)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_r  in  num_req  bit i = requester i pulling a datum
ack_r  out  num_req  one-cycle ack to granted requester; dout valid in same cycle
dout  out  data_width  datum delivered with ack_r
req_l  out  1  pull request to upstream source
ack_l  in  1  one-cycle ack from upstream source; din valid in same cycle
din  in  data_width  upstream datum
grant_idx  out  idx_width  index of the current/last grant
busy  out  1  high in any state other than IDLE
count  out  32  total data delivered since reset
err  out  1  sticky protocol-error flag

Behaviour:
- Reset: state IDLE; ack_r=0, dout=0, req_l=0, grant_idx=0, busy=0, count=0, err=0, data_r=0. last_grant=num_req-1, so the first search starts at requester 0.
- All outputs are registered. States: IDLE, FETCH, DELIVER, RELEASE.
- IDLE:
  - If req_r != 0, pick the first set bit scanning last_grant+1, last_grant+2, ... modulo num_req.
  - Load grant_idx, set req_l<=1, go to FETCH.
  - If req_r == 0, stay in IDLE.
- FETCH:
  - Hold req_l=1 until ack_l=1.
  - On ack_l: data_r<=din, req_l<=0, go to DELIVER.
  - The grant is locked. If req_r[grant_idx] drops, the fetch still completes and the datum is kept for that requester. Data is never lost, reordered, or redirected.
- DELIVER:
  - If req_r[grant_idx]=1: ack_r[grant_idx]<=1, dout<=data_r, count<=count+1, go to RELEASE.
  - Otherwise wait in DELIVER indefinitely. No other requester is served meanwhile.
- RELEASE: ack_r<=0, last_grant<=grant_idx, go to IDLE.
- Timing from edge k, where IDLE samples req:
  - k: req_l=1.
  - k+1: source ack.
  - k+2: capture, req_l=0.
  - k+3: ack_r pulse.
  - k+4: ack_r=0, IDLE.
  - k+5: next req_l.
  - Best-case throughput: 1 datum / 5 cycles.
- ack_r is at most one-hot. Each asserted pulse lasts exactly one cycle.
- req_l is never high outside FETCH (it is also high on the cycle FETCH is entered).
- ack_l while not in FETCH: ignored (no capture), err<=1. err clears only on rst.
- ack_l coinciding with the FETCH entry edge (req_l not yet visible): also flagged as err.
- count wraps modulo 2^32.
- Bits of req_r at index >= num_req do not exist. grant_idx never exceeds num_req-1.
- Reset mid-operation: a fetched but undelivered datum is discarded, and the next arbitration starts at requester 0. The upstream source is not acked back.

Optional Feature:
ARB_FIXED_PRIO_EN:
- Defined: fixed priority; the lowest set index of req_r always wins, and last_grant is unused.
- Undefined: round-robin as specified above.
- Handshake, timing and error behaviour are identical in both builds.

Test Plan:
- Only req_r[0] held high; source delivers 0,1,2 with ack one cycle after req_l → ack_r[0] pulses 5 cycles apart, dout=0,1,2, count=3, err=0.
- req_r=4'b1111 held; source counts from 0 → grant_idx sequence 0,1,2,3,0,1,2,3; requester i receives data i and i+4.
- Grant to 2; req_r[2] dropped during FETCH and reasserted 10 cycles later → datum held in DELIVER, no ack_r on any bit for those cycles, then ack_r[2] with the held value.
- ack_l pulse while IDLE with din=0xDEAD → err=1 and stays 1, no ack_r, dout unchanged, count unchanged.
- rst asserted for one cycle while in FETCH → next cycle req_l=0, ack_r=0, busy=0, count=0. With req_r=4'b1010, the first post-reset grant is 1.
- ARB_FIXED_PRIO_EN defined, req_r=4'b1010 held → only requester 1 is served, 20 consecutive deliveries all with grant_idx=1.

Source files
------------

// File: rtl/pull_rr_arbiter.sv
// pull_rr_arbiter: round-robin sharing of one pull-handshake source among num_req consumers; define ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module pull_rr_arbiter #(
  parameter int data_width = 32,
  parameter int num_req = 4,
  parameter int idx_width = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [num_req-1:0]    req_r,
  output logic [num_req-1:0]    ack_r,
  output logic [data_width-1:0] dout,
  output logic                  req_l,
  input  logic                  ack_l,
  input  logic [data_width-1:0] din,
  output logic [idx_width-1:0]  grant_idx,
  output logic                  busy,
  output logic [31:0]           count,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, FETCH, DELIVER, RELEASE} state_e;
  state_e state_q, state_d;
  logic [num_req-1:0] ack_q, ack_d, gnt_oh;
  logic [data_width-1:0] dout_q, dout_d, data_q, data_d;
  logic req_q, req_d, busy_q, err_q, err_d, found;
  logic [idx_width-1:0] grant_q, grant_d, base, pick;
  logic [31:0] count_q, count_d;
`ifdef ARB_FIXED_PRIO_EN
  assign base = idx_width'(num_req - 1);
`else
  logic [idx_width-1:0] last_q;
  always_ff @(posedge clk) begin
    if (rst) last_q <= idx_width'(num_req - 1);
    else if (state_q == RELEASE) last_q <= grant_q;
  end
  assign base = last_q;
`endif
  // scan starts one past base, so fixed priority is just a scan from index 0
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = 1; i <= num_req; i++) begin
      if (!found && |(req_r & (num_req'(1) << ((int'(base) + i) % num_req)))) begin
        pick = idx_width'((int'(base) + i) % num_req);
        found = 1'b1;
      end
    end
  end
  assign gnt_oh = num_req'(1) << grant_q;
  always_comb begin
    state_d = state_q;
    ack_d = '0;
    dout_d = dout_q;
    data_d = data_q;
    req_d = req_q;
    grant_d = grant_q;
    count_d = count_q;
    err_d = err_q | (ack_l && state_q != FETCH);
    case (state_q)
      IDLE: if (|req_r) begin
        grant_d = pick;
        req_d = 1'b1;
        state_d = FETCH;
      end
      FETCH: if (ack_l) begin
        data_d = din;
        req_d = 1'b0;
        state_d = DELIVER;
      end
      DELIVER: if (|(req_r & gnt_oh)) begin
        ack_d = gnt_oh;
        dout_d = data_q;
        count_d = count_q + 32'd1;
        state_d = RELEASE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q <= '0;
      dout_q <= '0;
      data_q <= '0;
      req_q <= 1'b0;
      grant_q <= '0;
      busy_q <= 1'b0;
      count_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q <= ack_d;
      dout_q <= dout_d;
      data_q <= data_d;
      req_q <= req_d;
      grant_q <= grant_d;
      busy_q <= state_d != IDLE;
      count_q <= count_d;
      err_q <= err_d;
    end
  end
  assign ack_r = ack_q;
  assign dout = dout_q;
  assign req_l = req_q;
  assign grant_idx = grant_q;
  assign busy = busy_q;
  assign count = count_q;
  assign err = err_q;
endmodule
